// File: rtl/adat_gen_pkg.sv
// adat_gen_pkg: shared LFSR geometry and default seed for the ADAT test-data source.
package adat_gen_pkg;
    localparam int LFSR_W = 15;
    localparam int TAP_A = 14;
    localparam int TAP_B = 13;
    localparam logic [LFSR_W-1:0] DEF_SEED = 15'h7FFF;
endpackage

// File: rtl/prbs_lfsr.sv
// prbs_lfsr: Fibonacci LFSR stepping one bit per enabled clock, with zero-state recovery.
module prbs_lfsr #(
    parameter int W = 15,
    parameter int TAP_A = 14,
    parameter int TAP_B = 13,
    parameter logic [W-1:0] SEED = '1
) (
    input  logic clock,
    input  logic reset,
    input  logic step,
    output logic bit_out
);
    // A zero seed would lock the register, so it is replaced by 1.
    localparam logic [W-1:0] INIT = (SEED == '0) ? W'(1) : SEED;
    logic [W-1:0] r_s;
    logic         w_fb;
    assign w_fb = r_s[TAP_A] ^ r_s[TAP_B];
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_s     <= INIT;
            bit_out <= 1'b0;
        end else if (step) begin
            r_s     <= (r_s == '0) ? W'(1) : {r_s[W-2:0], w_fb};
            bit_out <= w_fb;
        end
    end
endmodule

// File: rtl/adat_gen.sv
// adat_gen: PRBS-15 serial test data with a one-clock strobe on the first bit of each symbol.
module adat_gen
    import adat_gen_pkg::*;
#(
    parameter int SYMBOL_BITS = 4,
    parameter logic [LFSR_W-1:0] SEED = DEF_SEED
) (
    input  logic clock,
    input  logic reset,
    input  logic enable_cntr,
    output logic adat_ki,
    output logic data_change
);
    localparam int CNT_W = (SYMBOL_BITS > 1) ? $clog2(SYMBOL_BITS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SYMBOL_BITS - 1);
    logic [CNT_W-1:0] r_bit_cnt;
    prbs_lfsr #(
        .W(LFSR_W),
        .TAP_A(TAP_A),
        .TAP_B(TAP_B),
        .SEED(SEED)
    ) u_lfsr (
        .clock(clock),
        .reset(reset),
        .step(enable_cntr),
        .bit_out(adat_ki)
    );
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_bit_cnt   <= '0;
            data_change <= 1'b0;
        end else begin
            data_change <= enable_cntr && (r_bit_cnt == '0);
            if (enable_cntr) r_bit_cnt <= (r_bit_cnt == LAST) ? '0 : r_bit_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_adat_gen.sv
// tb_adat_gen: directed checks of adat_gen (default build) and a SEED=0 / SYMBOL_BITS=1 build.
module tb_adat_gen;
    logic clock = 1'b0;
    logic reset, enable_cntr;
    logic adat_ki, data_change, z_ki, z_dc;
    int   n_vec = 0, n_err = 0;
    logic [14:0] m_s, zm_s;
    int   m_cnt;
    logic m_ki, m_dc, zm_ki, zm_dc;
    logic ref_bits [0:39];

    always #5 clock = ~clock;

    adat_gen u_dut (
        .clock(clock), .reset(reset), .enable_cntr(enable_cntr),
        .adat_ki(adat_ki), .data_change(data_change)
    );
    adat_gen #(.SYMBOL_BITS(1), .SEED(15'h0000)) u_z (
        .clock(clock), .reset(reset), .enable_cntr(enable_cntr),
        .adat_ki(z_ki), .data_change(z_dc)
    );

    task automatic chk(input string tag, input logic got, input logic exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s = 15'h7FFF; m_cnt = 0; m_ki = 0; m_dc = 0;
        zm_s = 15'h0001; zm_ki = 0; zm_dc = 0;
    endtask

    task automatic tick(input logic en, input bit do_chk);
        logic fb;
        enable_cntr = en;
        @(posedge clock);
        #1;
        m_dc = en && (m_cnt == 0);
        zm_dc = en;
        if (en) begin
            fb = m_s[14] ^ m_s[13];
            m_s = (m_s == 0) ? 15'h0001 : {m_s[13:0], fb};
            m_ki = fb;
            m_cnt = (m_cnt == 3) ? 0 : m_cnt + 1;
            fb = zm_s[14] ^ zm_s[13];
            zm_s = (zm_s == 0) ? 15'h0001 : {zm_s[13:0], fb};
            zm_ki = fb;
        end
        if (do_chk) begin
            chk("ki", adat_ki, m_ki);
            chk("dc", data_change, m_dc);
            chk("z_ki", z_ki, zm_ki);
            chk("z_dc", z_dc, zm_dc);
        end
    endtask

    task automatic async_reset_check();
        @(posedge clock);
        #3 reset = 1'b1;
        #1;
        chk("async_ki", adat_ki, 1'b0);
        chk("async_dc", data_change, 1'b0);
        model_reset();
        @(posedge clock);
        #1 reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        enable_cntr = 1'b0;
        model_reset();
        for (int i = 0; i < 10; i++) begin
            #10 enable_cntr = ~enable_cntr;
            chk("rst_ki", adat_ki, 1'b0);
            chk("rst_dc", data_change, 1'b0);
            chk("rst_zdc", z_dc, 1'b0);
        end
        @(posedge clock);
        #1 reset = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick(1'b1, 1'b1);
            if (i == 1) chk("first_dc", data_change, 1'b1);
            if (i == 14) chk("bit14", adat_ki, 1'b0);
            if (i == 15) chk("bit15", adat_ki, 1'b1);
            if (i == 14) chk("z_bit14", z_ki, 1'b1);
        end
        for (int i = 0; i < 32; i++) tick(logic'(i[0]), 1'b1);
        async_reset_check();
        for (int i = 1; i <= 13; i++) tick(1'b1, 1'b1);
        chk("dc13", data_change, 1'b1);
        async_reset_check();
        tick(1'b1, 1'b1);
        chk("post_rst_dc", data_change, 1'b1);
        chk("post_rst_ki", adat_ki, 1'b0);
        for (int i = 2; i <= 15; i++) tick(1'b1, 1'b1);
        chk("mid_ki", adat_ki, 1'b1);
        async_reset_check();
        for (int k = 1; k <= 32767 + 40; k++) begin
            tick(1'b1, k <= 40);
            if (k <= 40) ref_bits[k-1] = adat_ki;
            if (k > 32767) chk("repeat", adat_ki, ref_bits[k-32768]);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
